// File: rtl/oser_pkg.sv
// Shared types and constants for the 10:1 output serializer lanes.
// Includes the lane sequencer state type and TMDS control words.
package oser_pkg;

  typedef enum logic [2:0] {
    OFF,
    RST_HOLD,
    CE_WAIT,
    TRAIN,
    RUN
  } oser_seq_state_t;

  localparam logic [9:0] TMDS_CTRL0 = 10'h354;
  localparam logic [9:0] TMDS_CTRL1 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL2 = 10'h154;
  localparam logic [9:0] TMDS_CTRL3 = 10'h2AB;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/oser10_lane_seq.sv
// Per-lane bring-up sequencer and word pump for the 10:1 serializer.
// Orders reset, clock-enable and training, then streams words.
module oser10_lane_seq
  import oser_pkg::*;
#(
  parameter int         RST_CYC    = 8,
  parameter int         CE_DLY     = 4,
  parameter int         TRAIN_CYC  = 64,
  parameter logic [9:0] TRAIN_WORD = TMDS_CTRL0,
  parameter logic [9:0] IDLE_WORD  = TMDS_CTRL1
) (
  input  logic        clk_par,
  input  logic        rst,
  input  logic        en,
  input  logic        restart,
  input  logic [9:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        oser_rst,
  output logic        oser_ce,
  output logic [9:0]  oser_d,
  output logic        link_up,
  output logic [15:0] underflow_cnt
);

  localparam int CW = cnt_width(RST_CYC, CE_DLY, TRAIN_CYC);
  localparam logic [CW-1:0] L_RST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] L_CE  = CW'(CE_DLY - 1);
  localparam logic [CW-1:0] L_TR  = CW'(TRAIN_CYC - 1);

  oser_seq_state_t r_state;
  oser_seq_state_t w_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_nxt_cnt;
  logic            r_oser_rst;
  logic            r_oser_ce;
  logic [9:0]      r_oser_d;
  logic            r_link_up;
  logic [15:0]     r_ucnt;
  logic            w_stay_run;

  assign s_ready       = (r_state == RUN);
  assign oser_rst      = r_oser_rst;
  assign oser_ce       = r_oser_ce;
  assign oser_d        = r_oser_d;
  assign link_up       = r_link_up;
  assign underflow_cnt = r_ucnt;
  assign w_stay_run    = (r_state == RUN) && (w_nxt == RUN);

  // Next state: disable beats restart, restart beats the timed walk.
  always_comb begin
    w_nxt     = r_state;
    w_nxt_cnt = r_cnt;
    if (!en) begin
      w_nxt     = OFF;
      w_nxt_cnt = '0;
    end else if (restart) begin
      w_nxt     = RST_HOLD;
      w_nxt_cnt = L_RST;
    end else begin
      unique case (r_state)
        OFF: begin
          w_nxt     = RST_HOLD;
          w_nxt_cnt = L_RST;
        end
        RST_HOLD: begin
          if (r_cnt == '0) begin
            w_nxt     = CE_WAIT;
            w_nxt_cnt = L_CE;
          end else begin
            w_nxt_cnt = r_cnt - 1'b1;
          end
        end
        CE_WAIT: begin
          if (r_cnt == '0) begin
            w_nxt     = TRAIN;
            w_nxt_cnt = L_TR;
          end else begin
            w_nxt_cnt = r_cnt - 1'b1;
          end
        end
        TRAIN: begin
          if (r_cnt == '0) begin
            w_nxt     = RUN;
            w_nxt_cnt = '0;
          end else begin
            w_nxt_cnt = r_cnt - 1'b1;
          end
        end
        RUN: w_nxt = RUN;
        default: begin
          w_nxt     = OFF;
          w_nxt_cnt = '0;
        end
      endcase
    end
  end

  // State and counter register.
  always_ff @(posedge clk_par) begin
    if (rst) begin
      r_state <= OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Outputs decoded from the next state so they switch with it.
  always_ff @(posedge clk_par) begin
    if (rst) begin
      r_oser_rst <= 1'b1;
      r_oser_ce  <= 1'b0;
      r_oser_d   <= IDLE_WORD;
      r_link_up  <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_oser_rst <= (w_nxt == OFF) || (w_nxt == RST_HOLD);
      r_oser_ce  <= (w_nxt == TRAIN) || (w_nxt == RUN);
      r_link_up  <= (w_nxt == RUN);
      if (w_stay_run) begin
        if (s_valid) begin
          r_oser_d <= s_data;
        end else begin
          r_oser_d <= IDLE_WORD;
          if (r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
        end
      end else if (w_nxt == TRAIN) begin
        r_oser_d <= TRAIN_WORD;
      end else begin
        r_oser_d <= IDLE_WORD;
      end
    end
  end

endmodule

// File: tb/tb_oser10_lane_seq.sv
// Scoreboard bench for the lane sequencer, default and 1/1/1 timing.
// Reference tracks elapsed bring-up time rather than a down-counter.
module tb_oser10_lane_seq;

  localparam logic [9:0] IDLE = 10'h0AB;
  localparam logic [9:0] TRW  = 10'h354;

  typedef struct {
    bit         off;
    int         t;
    logic [15:0] uc;
    logic       orst;
    logic       oce;
    logic       link;
    logic       rdy;
    logic [9:0] d;
  } ms_t;

  logic        clk = 1'b0;
  logic        rst, en, restart, s_valid;
  logic [9:0]  s_data;
  logic        rdy0, orst0, oce0, lk0;
  logic [9:0]  d0;
  logic [15:0] uc0;
  logic        rdy1, orst1, oce1, lk1;
  logic [9:0]  d1;
  logic [15:0] uc1;

  int checks = 0;
  int errors = 0;
  ms_t m0, m1;
  ms_t q0[$];
  ms_t q1[$];

  always #5 clk = ~clk;

  oser10_lane_seq u_dut0 (
    .clk_par(clk), .rst(rst), .en(en), .restart(restart),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy0),
    .oser_rst(orst0), .oser_ce(oce0), .oser_d(d0),
    .link_up(lk0), .underflow_cnt(uc0)
  );

  oser10_lane_seq #(
    .RST_CYC(1), .CE_DLY(1), .TRAIN_CYC(1)
  ) u_dut1 (
    .clk_par(clk), .rst(rst), .en(en), .restart(restart),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy1),
    .oser_rst(orst1), .oser_ce(oce1), .oser_d(d1),
    .link_up(lk1), .underflow_cnt(uc1)
  );

  function automatic ms_t mstep(
    input ms_t s, input int R, input int C, input int T,
    input bit r, input bit e, input bit rs,
    input bit v, input logic [9:0] dat
  );
    int  L;
    bit  prun, nrun;
    L    = R + C + T;
    prun = !s.off && (s.t >= L);
    if (r) begin
      s.off = 1; s.t = 0; s.uc = '0;
    end else if (!e) begin
      s.off = 1;
    end else if (s.off || rs) begin
      s.off = 0; s.t = 0;
    end else if (s.t < L) begin
      s.t++;
    end
    nrun   = !s.off && (s.t >= L);
    s.orst = s.off || (s.t < R);
    s.oce  = !s.off && (s.t >= R + C);
    s.link = nrun;
    s.rdy  = nrun;
    s.d    = IDLE;
    if (!s.off && s.t >= R + C && s.t < L) s.d = TRW;
    if (nrun && prun) begin
      if (v) s.d = dat;
      else if (s.uc != 16'hFFFF) s.uc = s.uc + 16'd1;
    end
    return s;
  endfunction

  task automatic drive(input bit r, input bit e, input bit rs,
                       input bit v, input logic [9:0] dat);
    rst = r; en = e; restart = rs; s_valid = v; s_data = dat;
    m0 = mstep(m0, 8, 4, 64, r, e, rs, v, dat);
    m1 = mstep(m1, 1, 1, 1, r, e, rs, v, dat);
    q0.push_back(m0);
    q1.push_back(m1);
    @(negedge clk);
  endtask

  task automatic cmp(input string nm, input ms_t x, input logic ar,
                     input logic ac, input logic al, input logic ay,
                     input logic [9:0] ad, input logic [15:0] au);
    checks++;
    if (ar !== x.orst || ac !== x.oce || al !== x.link ||
        ay !== x.rdy || ad !== x.d || au !== x.uc) begin
      errors++;
      $display("FAIL %s t=%0t got rst=%b ce=%b lk=%b rdy=%b d=%h uc=%h exp rst=%b ce=%b lk=%b rdy=%b d=%h uc=%h",
               nm, $time, ar, ac, al, ay, ad, au,
               x.orst, x.oce, x.link, x.rdy, x.d, x.uc);
    end
  endtask

  // Monitor: compare the bundle presented after every clock edge.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) cmp("lane_def", q0.pop_front(),
                           orst0, oce0, lk0, rdy0, d0, uc0);
    if (q1.size() > 0) cmp("lane_111", q1.pop_front(),
                           orst1, oce1, lk1, rdy1, d1, uc1);
  end

  initial begin
    m0 = '{off: 1, t: 0, uc: '0, orst: 1, oce: 0,
           link: 0, rdy: 0, d: IDLE};
    m1 = m0;
    repeat (3) drive(1, 0, 0, 0, 10'(0));
    repeat (80) drive(0, 1, 0, 1'($urandom), 10'($urandom));
    for (int i = 1; i <= 16; i++) drive(0, 1, 0, 1, 10'(i));
    repeat (5) drive(0, 1, 0, 0, 10'(0));
    repeat (300) drive(0, ($urandom_range(0, 99) != 0),
                       ($urandom_range(0, 79) == 0),
                       1'($urandom), 10'($urandom));
    drive(0, 1, 1, 0, 10'(0));
    repeat (41) drive(0, 1, 0, 1'($urandom), 10'($urandom));
    drive(0, 1, 1, 1, 10'($urandom));
    repeat (90) drive(0, 1, 0, 1'($urandom), 10'($urandom));
    drive(0, 0, 1, 1, 10'($urandom));
    repeat (3) drive(0, 0, 0, 1, 10'($urandom));
    repeat (90) drive(0, 1, 0, 1'($urandom), 10'($urandom));
    repeat (70000) drive(0, 1, 0, 0, 10'(0));
    repeat (4) drive(0, 1, 0, 1, 10'($urandom));
    drive(1, 1, 0, 1, 10'($urandom));
    repeat (20) drive(0, 1, 0, 1'($urandom), 10'($urandom));
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got q0=%0d q1=%0d exp 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
